// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM state type and wait counter width for the data memory
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_t;

endpackage

// File: rtl/memoria_dados_handshake_if.sv
// rtl/memoria_dados_handshake_if.sv - valid/ready request and response bundle between LSU and data memory
interface memoria_dados_handshake_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        resp_valid;
   logic [31:0] read_data;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_funct3, address, write_data,
      input  req_ready, resp_valid, read_data, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_funct3, address, write_data,
      output req_ready, resp_valid, read_data, resp_error
   );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-enable/store replication and load lane extraction; DMEM_MISALIGN_TRAP_EN traps misaligned accesses
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic        write,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  byte_en,
   output logic [31:0] store_word,
   output logic [31:0] load_data,
   output logic        error
);

   logic [1:0]  size;
   logic [1:0]  lane;
   logic        bad_f3;
   logic [31:0] shifted;

   always_comb begin
      size   = funct3[1:0];
      bad_f3 = 1'b1;
      case (funct3)
         F3_B, F3_H, F3_W: bad_f3 = 1'b0;
         F3_BU, F3_HU:     bad_f3 = write;
         default:          bad_f3 = 1'b1;
      endcase

`ifdef DMEM_MISALIGN_TRAP_EN
      lane  = addr_lo;
      error = bad_f3 | ((size == 2'b01) && addr_lo[0]) | ((size == 2'b10) && (addr_lo != 2'b00));
`else
      case (size)
         2'b01:   lane = {addr_lo[1], 1'b0};
         2'b10:   lane = 2'b00;
         default: lane = addr_lo;
      endcase
      error = bad_f3;
`endif

      byte_en = 4'b0000;
      if (write && !error) begin
         case (size)
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = 4'b0011 << lane;
            default: byte_en = 4'b1111;
         endcase
      end

      // Replicating the low lanes lets byte_en alone choose where the store lands
      case (size)
         2'b00:   store_word = {4{store_data[7:0]}};
         2'b01:   store_word = {2{store_data[15:0]}};
         default: store_word = store_data;
      endcase

      shifted   = load_word >> {lane, 3'b000};
      load_data = 32'd0;
      if (!write && !error) begin
         case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
         endcase
      end
   end

endmodule

// File: rtl/memoria_dados_handshake.sv
// rtl/memoria_dados_handshake.sv - RV32 byte/half/word data memory with valid/ready port and configurable wait states
module memoria_dados_handshake
   import dmem_pkg::*;
#(
   parameter int ADDR_BITS   = 12,
   parameter int WAIT_STATES = 1
) (
   input logic clock,
   input logic reset,
   memoria_dados_handshake_if.slave bus
);

   localparam int DEPTH = 2 ** (ADDR_BITS - 2);

   dmem_state_t            state;
   logic [WAIT_CNT_W-1:0]  wait_cnt;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [2:0]             funct3_q;
   logic                   write_q;
   logic [31:0]            wdata_q;

   logic [31:0] mem [DEPTH];

   logic [3:0]  byte_en;
   logic [31:0] store_word;
   logic [31:0] load_word;
   logic [31:0] load_data;
   logic        access_error;
   logic        unused_addr;

   // Upper address bits alias onto the decoded range
   assign unused_addr = ^bus.address[31:ADDR_BITS];
   assign load_word   = mem[addr_q[ADDR_BITS-1:2]];

   dmem_lane_align u_lane_align (
      .funct3     (funct3_q),
      .write      (write_q),
      .addr_lo    (addr_q[1:0]),
      .store_data (wdata_q),
      .load_word  (load_word),
      .byte_en    (byte_en),
      .store_word (store_word),
      .load_data  (load_data),
      .error      (access_error)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         wait_cnt       <= '0;
         addr_q         <= '0;
         funct3_q       <= '0;
         write_q        <= 1'b0;
         wdata_q        <= '0;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.read_data  <= '0;
         bus.resp_error <= 1'b0;
      end else begin
         bus.resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  addr_q        <= bus.address[ADDR_BITS-1:0];
                  funct3_q      <= bus.req_funct3;
                  write_q       <= bus.req_write;
                  wdata_q       <= bus.write_data;
                  bus.req_ready <= 1'b0;
                  if (WAIT_STATES == 0) begin
                     state <= ACCESS;
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= WAIT_CNT_W'(WAIT_STATES - 1);
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == '0) state <= ACCESS;
               else                wait_cnt <= wait_cnt - 1'b1;
            end
            ACCESS: begin
               bus.read_data  <= load_data;
               bus.resp_error <= access_error;
               bus.resp_valid <= 1'b1;
               state          <= RESP;
            end
            default: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
            end
         endcase
      end
   end

   // RAM is not reset; an asserted reset has already forced the FSM out of ACCESS
   always_ff @(posedge clock) begin
      if (!reset && state == ACCESS) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[addr_q[ADDR_BITS-1:2]][8*b +: 8] <= store_word[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_memoria_dados_handshake.sv
// tb/tb_memoria_dados_handshake.sv - directed self-checking bench for memoria_dados_handshake (WAIT_STATES 1 and 3)
module tb_memoria_dados_handshake;
   import dmem_pkg::*;

   logic clock;
   logic reset;
   int   tests_run;
   int   tests_failed;

   memoria_dados_handshake_if bus1 ();
   memoria_dados_handshake_if bus3 ();

   memoria_dados_handshake #(.ADDR_BITS(12), .WAIT_STATES(1)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1)
   );

   memoria_dados_handshake #(.ADDR_BITS(12), .WAIT_STATES(3)) dut3 (
      .clock (clock),
      .reset (reset),
      .bus   (bus3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // One request on dut1; inputs are scrambled right after accept to prove they were latched
   task automatic txn(input string tag, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
      int lat;
      @(negedge clock);
      check({tag, "_ready"}, 32'(bus1.req_ready), 32'd1);
      bus1.req_valid  = 1'b1;
      bus1.req_write  = wr;
      bus1.req_funct3 = f3;
      bus1.address    = addr;
      bus1.write_data = wd;
      @(posedge clock);
      #1;
      bus1.req_valid  = 1'b0;
      bus1.req_write  = ~wr;
      bus1.req_funct3 = 3'b111;
      bus1.address    = 32'hFFFF_FFFF;
      bus1.write_data = ~wd;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!bus1.resp_valid && lat < 40);
      check({tag, "_lat"}, 32'(lat), 32'd3);
      check({tag, "_rd"},  bus1.read_data, exp_rd);
      check({tag, "_err"}, 32'(bus1.resp_error), 32'(exp_err));
   endtask

   initial begin
      logic [31:0] got_ready;
      logic [31:0] got_resp;
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_funct3 = F3_W;
      bus1.address   = '0;   bus1.write_data = '0;
      bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_funct3 = 3'b011;
      bus3.address   = '0;   bus3.write_data = '0;

      @(negedge clock);
      check("rst_ready", 32'(bus1.req_ready), 32'd1);
      check("rst_resp",  32'(bus1.resp_valid), 32'd0);
      check("rst_rd",    bus1.read_data, 32'd0);
      check("rst_err",   32'(bus1.resp_error), 32'd0);
      reset = 1'b0;

      // Reset during WAIT drops the pending store
      txn("t1_sw0", 1'b1, F3_W, 32'h20, 32'h1111_1111, 32'h0, 1'b0);
      txn("t1_lw0", 1'b0, F3_W, 32'h20, 32'h0, 32'h1111_1111, 1'b0);
      @(negedge clock);
      bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_funct3 = F3_W;
      bus1.address = 32'h20; bus1.write_data = 32'h2222_2222;
      @(posedge clock);
      #1;
      bus1.req_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("t1_wrst_ready", 32'(bus1.req_ready), 32'd1);
      check("t1_wrst_resp",  32'(bus1.resp_valid), 32'd0);
      check("t1_wrst_rd",    bus1.read_data, 32'd0);
      check("t1_wrst_err",   32'(bus1.resp_error), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      txn("t1_lw1", 1'b0, F3_W, 32'h20, 32'h0, 32'h1111_1111, 1'b0);

      txn("t2_sw",   1'b1, F3_W, 32'h10,   32'hDEAD_BEEF, 32'h0, 1'b0);
      txn("t2_lw",   1'b0, F3_W, 32'h10,   32'h0, 32'hDEAD_BEEF, 1'b0);
      txn("t2_alias",1'b0, F3_W, 32'h1010, 32'h0, 32'hDEAD_BEEF, 1'b0);

      txn("t3_sb",  1'b1, F3_B,  32'h11, 32'h1234_5680, 32'h0, 1'b0);
      txn("t3_lb",  1'b0, F3_B,  32'h11, 32'h0, 32'hFFFF_FF80, 1'b0);
      txn("t3_lbu", 1'b0, F3_BU, 32'h11, 32'h0, 32'h0000_0080, 1'b0);
      txn("t3_lw",  1'b0, F3_W,  32'h10, 32'h0, 32'hDEAD_80EF, 1'b0);
      txn("t3_lh0", 1'b0, F3_H,  32'h10, 32'h0, 32'hFFFF_80EF, 1'b0);

      txn("t4_sh",  1'b1, F3_H,  32'h12, 32'hABCD_F234, 32'h0, 1'b0);
      txn("t4_lh",  1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF_F234, 1'b0);
      txn("t4_lhu", 1'b0, F3_HU, 32'h12, 32'h0, 32'h0000_F234, 1'b0);
      txn("t4_lw",  1'b0, F3_W,  32'h10, 32'h0, 32'hF234_80EF, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
      txn("t5_lw13",  1'b0, F3_W, 32'h13, 32'h0, 32'h0, 1'b1);
      txn("t5_sw11",  1'b1, F3_W, 32'h11, 32'h0, 32'h0, 1'b1);
      txn("t5_lwchk", 1'b0, F3_W, 32'h10, 32'h0, 32'hF234_80EF, 1'b0);
`else
      txn("t5_lw13",  1'b0, F3_W, 32'h13, 32'h0, 32'hF234_80EF, 1'b0);
      txn("t5_lwchk", 1'b0, F3_W, 32'h10, 32'h0, 32'hF234_80EF, 1'b0);
      txn("t5_sh13",  1'b1, F3_H, 32'h13, 32'h0000_1234, 32'h0, 1'b0);
      txn("t5_lwal",  1'b0, F3_W, 32'h10, 32'h0, 32'h1234_80EF, 1'b0);
      txn("t5_sw10",  1'b1, F3_W, 32'h10, 32'hF234_80EF, 32'h0, 1'b0);
`endif
      txn("t5_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
      txn("t5_f3_110", 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1);
      txn("t5_sbu",    1'b1, F3_BU,  32'h10, 32'h0, 32'h0, 1'b1);
      txn("t5_after",  1'b0, F3_W,   32'h10, 32'h0, 32'hF234_80EF, 1'b0);

      // WAIT_STATES=3 with req_valid held: accepts every 6 cycles, resp 5 cycles later
      got_ready = '0;
      got_resp  = '0;
      @(negedge clock);
      bus3.req_valid = 1'b1;
      for (int c = 0; c < 24; c++) begin
         if (c > 0) @(negedge clock);
         got_ready[c] = bus3.req_ready;
         got_resp[c]  = bus3.resp_valid;
      end
      bus3.req_valid = 1'b0;
      check("t6_ready_pattern", got_ready, 32'h0004_1041);
      check("t6_resp_pattern",  got_resp,  32'h0082_0820);
      check("t6_err",           32'(bus3.resp_error), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
